// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared state encoding, width derivation and locator seed width for fixed_sqrt
package sqrt_pkg;
    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;
    localparam int SEED_W = 6;
    function automatic int root_w(input int width, input int frac);
        return (width + frac) / 2;
    endfunction
    function automatic int rad_w(input int width, input int frac);
        return width + frac;
    endfunction
endpackage

// File: rtl/sqrt_trial.sv
// sqrt_trial: sets one candidate root bit and keeps it if the square still fits the radicand
module sqrt_trial #(
    parameter int ROOT_W = 8,
    parameter int RAD_W = 16,
    parameter int BIT_W = 3
) (
    input  logic [ROOT_W-1:0] root,
    input  logic [BIT_W-1:0]  bit_idx,
    input  logic [RAD_W-1:0]  radicand,
    output logic              accept,
    output logic [ROOT_W-1:0] next_root
);
    logic [ROOT_W-1:0] trial;
    logic [RAD_W:0]    t_ext;
    logic [RAD_W:0]    sq;
    always_comb begin
        trial = root | (ROOT_W'(1) << bit_idx);
        t_ext = (RAD_W + 1)'(trial);
        sq = t_ext * t_ext;
        accept = sq <= {1'b0, radicand};
        next_root = accept ? trial : root;
    end
endmodule

// File: rtl/fixed_sqrt.sv
// fixed_sqrt: bit-serial unsigned fixed-point square root, one root bit per clock from a
// seeded start bit down to bit 0, with start/busy/done handshake
module fixed_sqrt
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int FRAC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  operand,
    input  logic [SEED_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result
);
    localparam int ROOT_W = root_w(WIDTH, FRAC);
    localparam int RAD_W = rad_w(WIDTH, FRAC);
    localparam int BIT_W = $clog2(ROOT_W);
    state_t            state;
    logic [ROOT_W-1:0] root;
    logic [BIT_W-1:0]  bit_idx;
    logic [RAD_W-1:0]  radicand;
    logic [SEED_W:0]   sb_sum;
    logic [BIT_W-1:0]  start_bit;
    logic              accept;
    logic [ROOT_W-1:0] next_root;
    // The seed is only an upper bound, so clamp to the top root bit.
    always_comb begin
        sb_sum = (SEED_W + 1)'(FRAC) + (SEED_W + 1)'(seed);
        start_bit = (sb_sum > (SEED_W + 1)'(ROOT_W - 1)) ? BIT_W'(ROOT_W - 1) : sb_sum[BIT_W-1:0];
    end
    sqrt_trial #(.ROOT_W(ROOT_W), .RAD_W(RAD_W), .BIT_W(BIT_W)) u_trial (
        .root(root),
        .bit_idx(bit_idx),
        .radicand(radicand),
        .accept(accept),
        .next_root(next_root)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            root <= '0;
            bit_idx <= '0;
            radicand <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            result <= '0;
        end else if (state == IDLE) begin
            done <= 1'b0;
            if (start) begin
                radicand <= RAD_W'(operand) << FRAC;
                root <= '0;
                bit_idx <= start_bit;
                busy <= 1'b1;
                state <= CALC;
            end
        end else begin
            if (accept) root <= next_root;
            if (bit_idx == '0) begin
                result <= WIDTH'(next_root);
                done <= 1'b1;
                busy <= 1'b0;
                state <= IDLE;
            end else begin
                bit_idx <= bit_idx - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fixed_sqrt.sv
// tb_fixed_sqrt: directed checks of fixed_sqrt results, latency, busy window, start-while-busy and async reset
module tb_fixed_sqrt;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] operand = '0;
    logic [5:0]  seed = '0;
    logic        busy;
    logic        done;
    logic [11:0] result;
    int checks = 0;
    int failures = 0;

    fixed_sqrt #(.WIDTH(12), .FRAC(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .operand(operand),
        .seed(seed),
        .busy(busy),
        .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one start (optionally in the current done cycle) and waits, bounded, for done.
    task automatic op_run(input string tag, input logic [11:0] op, input logic [5:0] sd,
                          input logic [11:0] exp, input int lat, input bit b2b);
        int n = 0;
        int bcnt = 0;
        if (!b2b) @(negedge clk);
        start = 1'b1;
        operand = op;
        seed = sd;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (busy) bcnt++;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bcnt++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_busy"}, bcnt, lat);
    endtask

    initial begin
        int n;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        op_run("sq4", 12'h040, 6'd1, 12'h020, 6, 1'b0);
        @(posedge clk);
        #1;
        chk("done_pulse", done, 0);
        chk("result_hold", result, 12'h020);
        op_run("sq2", 12'h020, 6'd1, 12'h016, 6, 1'b0);
        op_run("sq025", 12'h004, 6'd0, 12'h008, 5, 1'b0);
        op_run("sqmax", 12'hFFF, 6'd4, 12'h0FF, 8, 1'b0);
        op_run("sq0", 12'h000, 6'd0, 12'h000, 5, 1'b0);
        op_run("sqbig", 12'h040, 6'd6, 12'h020, 8, 1'b0);

        // start while busy must be ignored
        @(negedge clk);
        start = 1'b1;
        operand = 12'h040;
        seed = 6'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        operand = 12'hFFF;
        seed = 6'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 2;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ignore_lat", n, 6);
        chk("ignore_res", result, 12'h020);
        op_run("b2b", 12'h020, 6'd1, 12'h016, 6, 1'b1);
        @(posedge clk);
        #1;
        chk("b2b_idle", busy, 0);

        // async reset mid-CALC
        op_run("pre_rst", 12'hFFF, 6'd4, 12'h0FF, 8, 1'b0);
        @(negedge clk);
        start = 1'b1;
        operand = 12'h020;
        seed = 6'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op_run("post_rst", 12'h004, 6'd0, 12'h008, 5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
